// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-ported data memory between CORES requesters.
// Define DMEM_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module dmem_arbiter #(
    parameter int unsigned CORES   = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2,
    localparam int unsigned OW     = (CORES > 1) ? $clog2(CORES) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CORES-1:0]         i_req,
    input  logic [CORES-1:0]         i_we,
    input  logic [CORES*ADDR_W-1:0]  i_addr,
    input  logic [CORES*DATA_W-1:0]  i_wdata,
    output logic [CORES-1:0]         o_done,
    output logic [DATA_W-1:0]        o_rdata,
    output logic                     o_mem_en,
    output logic                     o_mem_we,
    output logic [ADDR_W-1:0]        o_mem_addr,
    output logic [DATA_W-1:0]        o_mem_wdata,
    input  logic [DATA_W-1:0]        i_mem_rdata,
    output logic                     o_busy,
    output logic [OW-1:0]            o_owner
);

    localparam int unsigned CW = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [OW-1:0]     r_owner;
    logic [OW-1:0]     r_last_owner;
    logic [CORES-1:0]  r_done;
    logic [DATA_W-1:0] r_rdata;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_grant_vld;
    logic [OW-1:0]     w_grant_idx;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Scan downward so the lowest set index is the last (winning) assignment.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int i = int'(CORES) - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = OW'(i);
            end
        end
    end
`else
    always_comb begin : p_rr_pick
        logic [OW-1:0] idx;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        idx         = '0;
        for (int i = 1; i <= int'(CORES); i++) begin
            idx = OW'((int'(r_last_owner) + i) % int'(CORES));
            if (!w_grant_vld && i_req[idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = idx;
            end
        end
    end
`endif

    // The mem_* registers double as the latch for the granted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_owner      <= '0;
            r_last_owner <= OW'(CORES - 1);
            r_done       <= '0;
            r_rdata      <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_vld) begin
                        r_state     <= ST_ISSUE;
                        r_owner     <= w_grant_idx;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= i_we[w_grant_idx];
                        r_mem_addr  <= i_addr[w_grant_idx*ADDR_W +: ADDR_W];
                        r_mem_wdata <= i_wdata[w_grant_idx*DATA_W +: DATA_W];
                    end
                end
                ST_ISSUE: begin
                    r_mem_en <= 1'b0;
                    r_cnt    <= CW'(MEM_LAT);
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt == CW'(1)) begin
                        r_rdata <= i_mem_rdata;
                        r_done  <= CORES'(1) << r_owner;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_DONE: begin
                    r_done       <= '0;
                    r_last_owner <= r_owner;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_done      = r_done;
    assign o_rdata     = r_rdata;
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_owner     = r_owner;

endmodule
